// File: rtl/datapath_mc_param.sv
// datapath_mc_param
//   Multi-cycle LEGv8-style datapath. It contains the register file (the top
//   index is XZR), the ALU, the {V,C,N,Z} status register, the PC and the IR.
//   Plain multiplexers select every source. The control unit presents one
//   control word at a time with a valid/ready handshake. A word that touches
//   memory is latched, and a req/ack bus transaction runs with wait states
//   and a timeout. The word commits on the ack edge or is dropped on timeout.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   cw_valid / cw_ready     control word handshake; ready = word committed or
//                           consumed on this edge
//   FS,SA,SB,DA,w_reg,C0,   control word fields (ALU function, register
//   B_sel,data_sel,         indices, writeback/address/PC selection,
//   addr_sel,mem_rd,mem_wr, memory op, IR/status load, immediate)
//   IR_load,status_load,
//   PC_sel,PC_FS,k
//   mem_req,mem_we,         bus request, direction, address, write data
//   mem_addr,mem_wdata
//   mem_rdata,mem_ack       read data and transfer-complete from the bus
//   status,IR_out,PC_out    architectural state
//   bus_err                 sticky timeout flag, cleared only by reset
module datapath_mc_param #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int REG_CNT = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cw_valid,
  output logic                       cw_ready,
  input  logic [4:0]                 FS,
  input  logic [$clog2(REG_CNT)-1:0] SA,
  input  logic [$clog2(REG_CNT)-1:0] SB,
  input  logic [$clog2(REG_CNT)-1:0] DA,
  input  logic                       w_reg,
  input  logic                       C0,
  input  logic                       B_sel,
  input  logic [1:0]                 data_sel,
  input  logic                       addr_sel,
  input  logic                       mem_rd,
  input  logic                       mem_wr,
  input  logic                       IR_load,
  input  logic                       status_load,
  input  logic                       PC_sel,
  input  logic [1:0]                 PC_FS,
  input  logic [DATA_W-1:0]          k,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ack,
  output logic [3:0]                 status,
  output logic [31:0]                IR_out,
  output logic [ADDR_W-1:0]          PC_out,
  output logic                       bus_err
);

  localparam int IDX_W = $clog2(REG_CNT);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int SUM_W = DATA_W + 1;
  localparam int MSB   = DATA_W - 1;

  typedef struct packed {
    logic [4:0]        fs;
    logic [IDX_W-1:0]  sa;
    logic [IDX_W-1:0]  sb;
    logic [IDX_W-1:0]  da;
    logic              w_reg;
    logic              c0;
    logic              b_sel;
    logic [1:0]        data_sel;
    logic              addr_sel;
    logic              mem_rd;
    logic              mem_wr;
    logic              ir_load;
    logic              status_load;
    logic              pc_sel;
    logic [1:0]        pc_fs;
    logic [DATA_W-1:0] k;
  } cw_t;

  typedef enum logic {IDLE, BUS} state_t;

  state_t             state_reg;
  cw_t                cw_live;
  cw_t                cw_lat_reg;
  cw_t                act;
  logic [CNT_W-1:0]   tmo_cnt_reg;
  logic               mem_req_reg;
  logic               mem_we_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic [DATA_W-1:0]  mem_wdata_reg;
  logic               bus_err_reg;

  logic [DATA_W-1:0]  rf_reg [REG_CNT];
  logic [ADDR_W-1:0]  pc_reg;
  logic [31:0]        ir_reg;
  logic [3:0]         status_reg;

  logic [DATA_W-1:0]  a_val, rb_val, b_val, a_p, b_p, alu_f, wb_data;
  logic [SUM_W-1:0]   sum;
  logic               alu_c, alu_v;
  logic [3:0]         status_next;
  logic [ADDR_W-1:0]  pc_plus4, pc_next;
  logic [REG_CNT-1:0] wr_en;
  logic               mem_op, timeout_hit, commit, abort;

  always_comb begin
    cw_live             = '0;
    cw_live.fs          = FS;
    cw_live.sa          = SA;
    cw_live.sb          = SB;
    cw_live.da          = DA;
    cw_live.w_reg       = w_reg;
    cw_live.c0          = C0;
    cw_live.b_sel       = B_sel;
    cw_live.data_sel    = data_sel;
    cw_live.addr_sel    = addr_sel;
    cw_live.mem_rd      = mem_rd;
    cw_live.mem_wr      = mem_wr;
    cw_live.ir_load     = IR_load;
    cw_live.status_load = status_load;
    cw_live.pc_sel      = PC_sel;
    cw_live.pc_fs       = PC_FS;
    cw_live.k           = k;
  end

  // While a bus transfer is pending, the datapath works from the latched
  // word. The register file cannot change in that window, so the operands
  // match the values that were present when the word was accepted.
  assign act = (state_reg == BUS) ? cw_lat_reg : cw_live;

  // Register reads are combinational. XZR reads zero.
  assign a_val  = (act.sa == IDX_W'(REG_CNT - 1)) ? '0 : rf_reg[act.sa];
  assign rb_val = (act.sb == IDX_W'(REG_CNT - 1)) ? '0 : rf_reg[act.sb];
  assign b_val  = act.b_sel ? act.k : rb_val;

  always_comb begin
    a_p   = act.fs[1] ? ~a_val : a_val;
    b_p   = act.fs[0] ? ~b_val : b_val;
    sum   = SUM_W'(a_p) + SUM_W'(b_p) + SUM_W'(act.c0);
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (act.fs[4:2])
      3'b000: alu_f = a_p & b_p;
      3'b001: alu_f = a_p | b_p;
      3'b010: begin
        alu_f = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
        // Overflow occurs when both operands have the same sign and the sum has the other sign.
        alu_v = (a_p[MSB] == b_p[MSB]) && (alu_f[MSB] != a_p[MSB]);
      end
      3'b011: alu_f = a_p ^ b_p;
      3'b100: alu_f = a_p << b_p[5:0];
      3'b101: alu_f = a_p >> b_p[5:0];
      default: alu_f = '0;
    endcase
  end

  assign status_next = {alu_v, alu_c, alu_f[MSB], (alu_f == '0)};
  assign pc_plus4    = pc_reg + ADDR_W'(4);

  always_comb begin
    case (act.data_sel)
      2'b00:   wb_data = alu_f;
      2'b01:   wb_data = rb_val;
      2'b10:   wb_data = DATA_W'(pc_plus4);
      default: wb_data = mem_rdata;
    endcase
    case (act.pc_fs)
      2'b00:   pc_next = pc_reg;
      2'b01:   pc_next = pc_plus4;
      2'b10:   pc_next = pc_reg + (act.k[ADDR_W-1:0] << 2);
      default: pc_next = act.pc_sel ? act.k[ADDR_W-1:0] : a_val[ADDR_W-1:0];
    endcase
  end

  assign mem_op      = act.mem_rd | act.mem_wr;
  assign timeout_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign commit      = ((state_reg == IDLE) && cw_valid && !mem_op) ||
                       ((state_reg == BUS) && mem_ack);
  assign abort       = (state_reg == BUS) && !mem_ack && timeout_hit;
  assign cw_ready    = commit | abort;

  for (genvar gi = 0; gi < REG_CNT; gi++) begin : g_wr_en
    if (gi == REG_CNT - 1) begin : g_xzr
      assign wr_en[gi] = 1'b0;
    end else begin : g_gpr
      assign wr_en[gi] = commit && act.w_reg && (act.da == IDX_W'(gi));
    end
  end

  // Bus handshake FSM. All bus outputs are registered and stay constant for the whole transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cw_lat_reg    <= '0;
      tmo_cnt_reg   <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      bus_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cw_valid && mem_op) begin
            cw_lat_reg    <= cw_live;
            tmo_cnt_reg   <= '0;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= cw_live.mem_wr;  // read+write is treated as a write
            mem_addr_reg  <= cw_live.addr_sel ? pc_reg : alu_f[ADDR_W-1:0];
            mem_wdata_reg <= rb_val;
            state_reg     <= BUS;
          end
        end
        BUS: begin
          if (mem_ack || timeout_hit) begin
            mem_req_reg <= 1'b0;
            state_reg   <= IDLE;
            if (!mem_ack) bus_err_reg <= 1'b1;  // ack takes priority over timeout
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Architectural state. Every update happens on the commit edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_CNT; i++) rf_reg[i] <= '0;
      pc_reg     <= '0;
      ir_reg     <= '0;
      status_reg <= '0;
    end else if (commit) begin
      for (int i = 0; i < REG_CNT; i++) begin
        if (wr_en[i]) rf_reg[i] <= wb_data;
      end
      if (act.status_load) status_reg <= status_next;
      if (act.ir_load) ir_reg <= mem_rdata[31:0];
      pc_reg <= pc_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign bus_err   = bus_err_reg;
  assign status    = status_reg;
  assign IR_out    = ir_reg;
  assign PC_out    = pc_reg;

endmodule

// File: tb/tb_datapath_mc_param.sv
`timescale 1ns/1ps
module tb_datapath_mc_param;

  localparam int TMO = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        cw_valid, cw_ready;
  logic [4:0]  FS, SA, SB, DA;
  logic        w_reg, C0, B_sel, addr_sel, mem_rd, mem_wr, IR_load, status_load, PC_sel;
  logic [1:0]  data_sel, PC_FS;
  logic [63:0] k, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, IR_out, PC_out;
  logic [3:0]  status;

  datapath_mc_param #(.DATA_W(64), .ADDR_W(32), .REG_CNT(32), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .FS(FS), .SA(SA), .SB(SB), .DA(DA), .w_reg(w_reg), .C0(C0), .B_sel(B_sel),
    .data_sel(data_sel), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .IR_load(IR_load), .status_load(status_load), .PC_sel(PC_sel), .PC_FS(PC_FS),
    .k(k), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .status(status), .IR_out(IR_out), .PC_out(PC_out), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [63:0] m_rf [32];
  logic [31:0] m_pc, m_ir;
  logic [3:0]  m_status;
  logic        m_bus_err;

  int checks = 0;
  int errors = 0;
  int txn_n  = 0;
  int req_cycles;
  logic [63:0] last_wdata;
  logic [31:0] last_addr;

  localparam logic signed [66:0] S_MAX = 67'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [66:0] S_MIN = -67'sh0_8000_0000_0000_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    m_pc = 32'd0; m_ir = 32'd0; m_status = 4'd0; m_bus_err = 1'b0;
  endtask

  // The ALU is modelled with integer arithmetic. Signed overflow is decided by
  // a range test on a wide signed sum.
  function automatic void model_alu(input logic [63:0] a, input logic [63:0] b, input logic [4:0] fs,
                                    input logic c0, output logic [63:0] f, output logic cf, output logic vf);
    logic [63:0] ap, bp;
    logic [64:0] u;
    logic signed [66:0] t;
    ap = fs[1] ? ~a : a;
    bp = fs[0] ? ~b : b;
    cf = 1'b0; vf = 1'b0; f = 64'd0;
    case (fs[4:2])
      3'd0: f = ap & bp;
      3'd1: f = ap | bp;
      3'd2: begin
        u  = {1'b0, ap} + {1'b0, bp} + {64'd0, c0};
        f  = u[63:0];
        cf = u[64];
        t  = $signed({{3{ap[63]}}, ap}) + $signed({{3{bp[63]}}, bp}) + $signed({66'd0, c0});
        vf = (t > S_MAX) || (t < S_MIN);
      end
      3'd3: f = ap ^ bp;
      3'd4: f = ap << bp[5:0];
      3'd5: f = ap >> bp[5:0];
      default: f = 64'd0;
    endcase
  endfunction

  task automatic model_commit(input logic [63:0] a, input logic [63:0] f, input logic cf, input logic vf,
                              input logic [63:0] rb, input logic [63:0] rdata);
    logic [63:0] wb;
    case (data_sel)
      2'd0:    wb = f;
      2'd1:    wb = rb;
      2'd2:    wb = {32'd0, m_pc + 32'd4};
      default: wb = rdata;
    endcase
    if (w_reg && DA != 5'd31) m_rf[DA] = wb;
    if (status_load) m_status = {vf, cf, f[63], f == 64'd0};
    if (IR_load) m_ir = rdata[31:0];
    case (PC_FS)
      2'd1:    m_pc = m_pc + 32'd4;
      2'd2:    m_pc = m_pc + k[31:0] * 32'd4;
      2'd3:    m_pc = PC_sel ? k[31:0] : a[31:0];
      default: ;
    endcase
  endtask

  task automatic clear_cw();
    FS = 5'd0; SA = 5'd31; SB = 5'd31; DA = 5'd0; w_reg = 1'b0; C0 = 1'b0; B_sel = 1'b0;
    data_sel = 2'd0; addr_sel = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; IR_load = 1'b0;
    status_load = 1'b0; PC_sel = 1'b0; PC_FS = 2'd0; k = 64'd0;
  endtask

  // Run one control word to completion. ack_at is the BUS cycle (1-based) in
  // which mem_ack is raised. A value of 0 means no ack is given.
  // Called and returns at posedge+1.
  task automatic run_op(input int ack_at, input logic [63:0] rdata);
    logic [63:0] a, rb, b, f;
    logic cf, vf;
    logic [31:0] eaddr;
    bit is_mem, done;
    a  = (SA == 5'd31) ? 64'd0 : m_rf[SA];
    rb = (SB == 5'd31) ? 64'd0 : m_rf[SB];
    b  = B_sel ? k : rb;
    model_alu(a, b, FS, C0, f, cf, vf);
    eaddr  = addr_sel ? m_pc : f[31:0];
    is_mem = mem_rd || mem_wr;
    req_cycles = 0;
    txn_n++;
    $display("txn %0d fs=%b sa=%0d sb=%0d da=%0d wr_en=%b rd=%b wr=%b ack_at=%0d pc=%h",
             txn_n, FS, SA, SB, DA, w_reg, mem_rd, mem_wr, ack_at, m_pc);
    cw_valid = 1'b1;
    @(negedge clock);
    check("cw_ready_idle", 64'(cw_ready), 64'(!is_mem));
    check("mem_req_idle", 64'(mem_req), 64'd0);
    @(posedge clock); #1;
    if (!is_mem) begin
      model_commit(a, f, cf, vf, rb, mem_rdata);
    end else begin
      done = 1'b0;
      for (int i = 1; i <= TMO && !done; i++) begin
        if (i == ack_at) begin mem_ack = 1'b1; mem_rdata = rdata; end
        @(negedge clock);
        if (mem_req) req_cycles++;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        check("mem_req_bus", 64'(mem_req), 64'd1);
        check("mem_we", 64'(mem_we), 64'(mem_wr));
        check("mem_addr", 64'(mem_addr), 64'(eaddr));
        if (mem_wr) check("mem_wdata", mem_wdata, rb);
        check("cw_ready_bus", 64'(cw_ready), 64'((i == ack_at) || (i == TMO)));
        @(posedge clock); #1;
        mem_ack = 1'b0;
        if (i == ack_at) begin model_commit(a, f, cf, vf, rb, rdata); done = 1'b1; end
        else if (i == TMO) begin m_bus_err = 1'b1; done = 1'b1; end
      end
    end
    cw_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    @(negedge clock);
    check("pc", 64'(PC_out), 64'(m_pc));
    check("ir", 64'(IR_out), 64'(m_ir));
    check("status", 64'(status), 64'(m_status));
    check("bus_err", 64'(bus_err), 64'(m_bus_err));
    check("mem_req_after", 64'(mem_req), 64'd0);
    check("cw_ready_after", 64'(cw_ready), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic op_imm(input logic [4:0] da, input logic [4:0] sa, input logic [4:0] fs,
                        input logic [63:0] kk, input logic c0, input logic sl);
    clear_cw();
    DA = da; SA = sa; FS = fs; k = kk; C0 = c0; B_sel = 1'b1; w_reg = 1'b1; status_load = sl;
    run_op(0, 64'd0);
  endtask

  // A memory write of SB with an immediate ack exposes the register on mem_wdata.
  task automatic peek(input logic [4:0] r);
    clear_cw();
    SB = r; SA = 5'd31; FS = 5'b00100; B_sel = 1'b1; mem_wr = 1'b1;
    run_op(1, 64'd0);
  endtask

  task automatic rand_op();
    int sel, ack_at;
    logic [63:0] rd;
    clear_cw();
    FS = 5'($urandom_range(0, 31));
    SA = 5'($urandom_range(0, 31)); SB = 5'($urandom_range(0, 31)); DA = 5'($urandom_range(0, 31));
    w_reg = 1'($urandom_range(0, 1)); C0 = 1'($urandom_range(0, 1)); B_sel = 1'($urandom_range(0, 1));
    status_load = 1'($urandom_range(0, 1)); PC_sel = 1'($urandom_range(0, 1));
    PC_FS = 2'($urandom_range(0, 3)); addr_sel = 1'($urandom_range(0, 1));
    k = {$urandom(), $urandom()};
    rd = {$urandom(), $urandom()};
    sel = int'($urandom_range(0, 5));
    ack_at = int'($urandom_range(1, 5));
    if (sel >= 3) begin
      mem_rd = (sel != 4);
      mem_wr = (sel != 3);
      if (mem_wr) data_sel = 2'($urandom_range(0, 2));
      else begin data_sel = 2'($urandom_range(0, 3)); IR_load = 1'($urandom_range(0, 1)); end
    end else begin
      data_sel = 2'($urandom_range(0, 2));
    end
    run_op(ack_at, rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cw_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 64'd0;
    clear_cw();
    model_reset();
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_pc", 64'(PC_out), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_ir", 64'(IR_out), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    check("rst_cw_ready", 64'(cw_ready), 64'd0);
    @(posedge clock); #1;

    // ADD X2 = X1 + 3 with status
    op_imm(5'd1, 5'd31, 5'b00100, 64'd5, 1'b0, 1'b0);
    op_imm(5'd2, 5'd1, 5'b01000, 64'd3, 1'b0, 1'b1);
    check("add_status", 64'(status), 64'h0);
    peek(5'd2);
    check("add_x2", last_wdata, 64'd8);

    // SUB X1 - X3 where both are 3
    op_imm(5'd1, 5'd31, 5'b00100, 64'd3, 1'b0, 1'b0);
    op_imm(5'd3, 5'd31, 5'b00100, 64'd3, 1'b0, 1'b0);
    clear_cw();
    FS = 5'b01001; SA = 5'd1; SB = 5'd3; C0 = 1'b1; status_load = 1'b1;
    run_op(0, 64'd0);
    check("sub_status", 64'(status), 64'h5);

    // Signed overflow
    op_imm(5'd1, 5'd31, 5'b00100, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    op_imm(5'd6, 5'd1, 5'b01000, 64'd1, 1'b0, 1'b1);
    check("ovf_status", 64'(status), 64'hA);

    // Load with three wait states
    clear_cw();
    SA = 5'd31; FS = 5'b00100; B_sel = 1'b1; k = 64'h100; mem_rd = 1'b1;
    w_reg = 1'b1; DA = 5'd4; data_sel = 2'd3;
    run_op(4, 64'hDEAD);
    check("ld_req_cycles", 64'(req_cycles), 64'd4);
    check("ld_addr", 64'(last_addr), 64'h100);
    peek(5'd4);
    check("ld_x4", last_wdata, 64'hDEAD);

    // Write that is never acknowledged
    clear_cw();
    SA = 5'd31; SB = 5'd2; FS = 5'b00100; B_sel = 1'b1; k = 64'h77; mem_wr = 1'b1;
    w_reg = 1'b1; DA = 5'd5; PC_FS = 2'd1;
    run_op(0, 64'd0);
    check("tmo_req_cycles", 64'(req_cycles), 64'd15);
    check("tmo_bus_err", 64'(bus_err), 64'd1);
    peek(5'd5);
    check("tmo_x5", last_wdata, 64'd0);

    // PC wrap, and a negative branch offset
    clear_cw(); PC_FS = 2'd3; PC_sel = 1'b1; k = 64'hFFFF_FFFC; run_op(0, 64'd0);
    clear_cw(); PC_FS = 2'd1; run_op(0, 64'd0);
    check("pc_wrap", 64'(PC_out), 64'd0);
    clear_cw(); PC_FS = 2'd3; PC_sel = 1'b1; k = 64'd8; run_op(0, 64'd0);
    clear_cw(); PC_FS = 2'd2; k = '1; run_op(0, 64'd0);
    check("pc_branch", 64'(PC_out), 64'd4);

    // XZR ignores writes
    op_imm(5'd31, 5'd31, 5'b00100, 64'h1234, 1'b0, 1'b0);
    peek(5'd31);
    check("xzr", last_wdata, 64'd0);

    for (int n = 0; n < 150; n++) rand_op();

    // Reset while a transfer is waiting for ack
    clear_cw();
    SA = 5'd31; FS = 5'b00100; B_sel = 1'b1; k = 64'h40; mem_rd = 1'b1;
    w_reg = 1'b1; DA = 5'd2; data_sel = 2'd3; PC_FS = 2'd1;
    cw_valid = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("rstbus_req_pre", 64'(mem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rstbus_req", 64'(mem_req), 64'd0);
    check("rstbus_pc", 64'(PC_out), 64'd0);
    cw_valid = 1'b0; clear_cw();
    mem_ack = 1'b1; mem_rdata = 64'hBEEF;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    check("rstbus_req_post", 64'(mem_req), 64'd0);
    check("rstbus_pc_post", 64'(PC_out), 64'd0);
    check("rstbus_err", 64'(bus_err), 64'd0);
    @(posedge clock); #1;
    peek(5'd1);
    check("rstbus_x1", last_wdata, 64'd0);
    peek(5'd2);
    check("rstbus_x2", last_wdata, 64'd0);

    for (int n = 0; n < 20; n++) rand_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
